ysyx_210184_mem_stage: RTL

- Memory-access pipeline stage that consumes the registered EX-stage outputs: load/store enables, access size code, ALU result used as the address, and store data.
- Drives a valid/ready request plus response-valid data-memory port through a small FSM.
- Holds the pipeline with stall_o while an access is outstanding.
- Produces the registered write-back bundle (rd, enable, data) that feeds the EX forwarding path and the WB stage.

---
 rtl/ysyx_210184_mem_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_210184_mem_stage.sv
// Memory-access pipeline stage: turns the EX-stage load/store bundle into a
// valid/ready data-memory request, stalls upstream while the access is in
// flight, and registers the write-back bundle for forwarding and WB.
module ysyx_210184_mem_stage #(
  parameter int REG_BUS = 64,
  parameter int MASK_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_ena_i,
  input  logic               store_ena_i,
  input  logic [2:0]         load_store_bytes_i,
  input  logic [REG_BUS-1:0] addr_i,
  input  logic [REG_BUS-1:0] rs2_data_i,
  input  logic [4:0]         rd_i,
  input  logic               w_rd_ena_i,
  input  logic               inst_valid_i,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_wen,
  output logic [REG_BUS-1:0] mem_req_addr,
  output logic [REG_BUS-1:0] mem_req_wdata,
  output logic [MASK_W-1:0]  mem_req_wmask,
  input  logic               mem_rsp_valid,
  input  logic [REG_BUS-1:0] mem_rsp_rdata,
  output logic               stall_o,
  output logic [4:0]         rd_o,
  output logic               w_rd_ena_o,
  output logic [REG_BUS-1:0] wb_data_o,
  output logic               inst_valid_o,
  output logic               misalign_o
);

  localparam int OFF_W = $clog2(MASK_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [REG_BUS-1:0] r_addr;
  logic               r_wen;
  logic [REG_BUS-1:0] r_wdata;
  logic [MASK_W-1:0]  r_wmask;
  logic [2:0]         r_size;
  logic [OFF_W-1:0]   r_off;
  logic [4:0]         r_rd;
  logic               r_rdEna;

  logic               w_isMem;
  logic [1:0]         w_size;
  logic [OFF_W-1:0]   w_off;
  logic               w_misalign;
  logic [MASK_W-1:0]  w_baseMask;
  logic               w_startAccess;
  logic               w_finish;
  logic [REG_BUS-1:0] w_shifted;
  logic [REG_BUS-1:0] w_loadData;

  assign w_isMem       = load_ena_i | store_ena_i;
  assign w_size        = load_store_bytes_i[1:0];
  assign w_off         = addr_i[OFF_W-1:0];
  assign w_startAccess = (r_state == IDLE) & w_isMem & ~w_misalign;
  assign w_finish      = (r_state == RESP) & mem_rsp_valid;
  assign w_shifted     = mem_rsp_rdata >> {r_off, 3'b000};

  assign mem_req_wen   = r_wen;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;

  // Size decode: the low two code bits give the access width (111 folds onto ld).
  always_comb begin
    w_misalign = 1'b0;
    w_baseMask = MASK_W'(8'h01);
    case (w_size)
      2'd0: begin
        w_misalign = 1'b0;
        w_baseMask = MASK_W'(8'h01);
      end
      2'd1: begin
        w_misalign = addr_i[0];
        w_baseMask = MASK_W'(8'h03);
      end
      2'd2: begin
        w_misalign = |addr_i[1:0];
        w_baseMask = MASK_W'(8'h0F);
      end
      default: begin
        w_misalign = |addr_i[2:0];
        w_baseMask = MASK_W'(8'hFF);
      end
    endcase
  end

  // Load extraction: pick the addressed lane and sign/zero-extend it.
  always_comb begin
    w_loadData = w_shifted;
    case (r_size)
      3'b000:  w_loadData = {{(REG_BUS-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_loadData = {{(REG_BUS-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_loadData = {{(REG_BUS-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_loadData = {{(REG_BUS-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_loadData = {{(REG_BUS-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_loadData = {{(REG_BUS-32){1'b0}}, w_shifted[31:0]};
      default: w_loadData = w_shifted;
    endcase
    if (r_wen) begin
      w_loadData = '0;
    end
  end

  // FSM state register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: wait for the handshake in REQ, then the response in RESP.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startAccess) w_nextState = REQ;
      REQ:     if (mem_req_ready) w_nextState = RESP;
      RESP:    if (mem_rsp_valid) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: stall drops in the response cycle so upstream advances with us.
  always_comb begin
    mem_req_valid = 1'b0;
    stall_o       = 1'b0;
    case (r_state)
      IDLE: stall_o = w_isMem & ~w_misalign;
      REQ: begin
        mem_req_valid = 1'b1;
        stall_o       = 1'b1;
      end
      RESP:    stall_o = ~mem_rsp_valid;
      default: stall_o = 1'b0;
    endcase
    stall_o = stall_o & rst;
  end

  // Request latches, captured once when an aligned access leaves IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_size  <= '0;
      r_off   <= '0;
      r_rd    <= '0;
      r_rdEna <= 1'b0;
    end else if (w_startAccess) begin
      r_addr  <= {addr_i[REG_BUS-1:OFF_W], {OFF_W{1'b0}}};
      r_wen   <= store_ena_i;
      r_wdata <= rs2_data_i << {w_off, 3'b000};
      r_wmask <= w_baseMask << w_off;
      r_size  <= load_store_bytes_i;
      r_off   <= w_off;
      r_rd    <= rd_i;
      r_rdEna <= w_rd_ena_i & ~store_ena_i;
    end
  end

  // Write-back bundle: pass-through, bubble, misalign flag or completed access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_o         <= '0;
      w_rd_ena_o   <= 1'b0;
      wb_data_o    <= '0;
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (!w_isMem) begin
        rd_o         <= rd_i;
        w_rd_ena_o   <= w_rd_ena_i;
        wb_data_o    <= addr_i;
        inst_valid_o <= inst_valid_i;
        misalign_o   <= 1'b0;
      end else if (w_misalign) begin
        rd_o         <= rd_i;
        w_rd_ena_o   <= 1'b0;
        wb_data_o    <= '0;
        inst_valid_o <= inst_valid_i;
        misalign_o   <= 1'b1;
      end else begin
        w_rd_ena_o   <= 1'b0;
        inst_valid_o <= 1'b0;
        misalign_o   <= 1'b0;
      end
    end else if (w_finish) begin
      rd_o         <= r_rd;
      w_rd_ena_o   <= r_rdEna;
      wb_data_o    <= w_loadData;
      inst_valid_o <= 1'b1;
      misalign_o   <= 1'b0;
    end
  end

endmodule
